// File: rtl/addrs_pkg.sv
// Shared types and helpers for the addrs_pipe pipelined add/subtract block.
//
// Contents:
//   MAX_W        widest operand the payload struct can carry (WIDTH must be < MAX_W)
//   stage_t      per-stage payload: valid, partial sum, carry, operands, mod-3 residues
//   calc_stages  number of pipeline stages for a given width and chunk size
//   mod3         mod-3 residue of an n-bit two's complement value
//   neg3         mod-3 residue of the negation of a value, given its residue
package addrs_pkg;

  localparam int MAX_W = 64;

  // Operand and sum fields are fixed at MAX_W+1 bits; only bits [WIDTH:0]
  // carry meaning and everything above stays zero.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W:0]   sum;
    logic [MAX_W:0]   a;
    logic [MAX_W:0]   b;
    logic [1:0]       res_a;
    logic [1:0]       res_b;
  } stage_t;

  function automatic int calc_stages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Bit i weighs 2^i mod 3 = 1 (i even) or 2 (i odd); the sign bit weighs
  // -2^(n-1), i.e. the complementary residue.
  function automatic logic [1:0] mod3(input logic [MAX_W:0] x, input int n);
    int acc;
    acc = 0;
    for (int i = 0; i <= MAX_W; i++) begin
      if (i < n && x[i]) begin
        if (i == n - 1) acc = acc + ((i % 2 == 0) ? 2 : 1);
        else            acc = acc + ((i % 2 == 0) ? 1 : 2);
      end
    end
    return 2'(acc % 3);
  endfunction

  function automatic logic [1:0] neg3(input logic [1:0] r);
    return (r == 2'd0) ? 2'd0 : 2'(3 - int'(r));
  endfunction

endpackage

// File: rtl/addrs_stage.sv
// One carry-chain slice of the addrs_pipe adder with its valid/advance register.
//
// Parameters:
//   LO, HI      bit range [LO, HI) of the sum resolved by this slice
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (clears the valid bit only)
//   d           payload from the previous stage (or the input port)
//   next_ready  downstream stage is empty or advancing
//   ready       this stage loads d on the coming edge
//   q           registered payload presented to the next stage
module addrs_stage
  import addrs_pkg::*;
#(
  parameter int LO = 0,
  parameter int HI = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t d,
  input  logic   next_ready,
  output logic   ready,
  output stage_t q
);

  stage_t nxt;
  stage_t pay_p0;
  logic   vld_p0;

  // Ripple the registered carry through this slice's bits only.
  always_comb begin
    logic c;
    nxt = d;
    c   = d.carry;
    for (int i = 0; i <= MAX_W; i++) begin
      if (i >= LO && i < HI) begin
        nxt.sum[i] = d.a[i] ^ d.b[i] ^ c;
        c          = (d.a[i] & d.b[i]) | (c & (d.a[i] ^ d.b[i]));
      end
    end
    nxt.carry = c;
  end

  // An empty slot always loads, so bubbles collapse at full throughput.
  assign ready = !vld_p0 || next_ready;

  // ---- stage register ----
  always_ff @(posedge clk) begin
    if (rst)        vld_p0 <= 1'b0;
    else if (ready) vld_p0 <= d.valid;
  end

  always_ff @(posedge clk) begin
    if (ready && d.valid) pay_p0 <= nxt;
  end

  always_comb begin
    q       = pay_p0;
    q.valid = vld_p0;
  end

endmodule

// File: rtl/addrs_pipe.sv
// Pipelined signed adder/subtractor with exact WIDTH+1-bit result and
// valid/ready handshakes on both sides.  The carry chain is cut into CHUNK-bit
// slices, one per pipeline stage.
//
// Optional feature: define ADDRS_RESIDUE_CHECK_EN to carry mod-3 residues of
// A and effective B alongside the data and flag results whose residue does
// not match.  Without it out_err is 0 and err_cnt stays 0.
//
// Parameters:
//   WIDTH      operand width (>= 2, < MAX_W)
//   CHUNK      carry-chain bits per stage (1..WIDTH)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair present
//   in_ready   operands accepted this cycle
//   in_a/in_b  signed operands
//   in_sub     0: A+B, 1: A-B
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_sum    exact signed result (0 when out_valid is 0)
//   out_err    residue mismatch on the presented result
//   err_cnt    saturating count of transferred results with out_err set
module addrs_pipe
  import addrs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH:0]   out_sum,
  output logic                    out_err,
  output logic [7:0]              err_cnt
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  stage_t              st_d     [STAGES];
  stage_t              st_q     [STAGES];
  logic                st_ready [STAGES+1];
  stage_t              in_pay;
  stage_t              last;
  logic signed [WIDTH:0] a_sx;
  logic signed [WIDTH:0] b_sx;
  logic [WIDTH:0]      last_sum;

  assign a_sx = {in_a[WIDTH-1], in_a};
  assign b_sx = {in_b[WIDTH-1], in_b};

  // Subtraction is A + ~B with carry-in 1, so stage 0 needs no special case.
  always_comb begin
    in_pay            = '0;
    in_pay.valid      = in_valid && in_ready;
    in_pay.carry      = in_sub;
    in_pay.a[WIDTH:0] = a_sx;
    in_pay.b[WIDTH:0] = in_sub ? ~b_sx : b_sx;
`ifdef ADDRS_RESIDUE_CHECK_EN
    begin
      logic [MAX_W:0] b_raw;
      logic [1:0]     rb;
      b_raw            = '0;
      b_raw[WIDTH:0]   = b_sx;
      rb               = mod3(b_raw, WIDTH + 1);
      in_pay.res_a     = mod3(in_pay.a, WIDTH + 1);
      in_pay.res_b     = in_sub ? neg3(rb) : rb;
    end
`endif
  end

  // ---- stage k resolves bits [k*CHUNK, min((k+1)*CHUNK, WIDTH)); the last also bit WIDTH ----
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int HI = (k == STAGES - 1) ? WIDTH + 1 : (k + 1) * CHUNK;

    if (k == 0) begin : g_first
      assign st_d[k] = in_pay;
    end else begin : g_next
      assign st_d[k] = st_q[k-1];
    end

    addrs_stage #(
      .LO (LO),
      .HI (HI)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .d          (st_d[k]),
      .next_ready (st_ready[k+1]),
      .ready      (st_ready[k]),
      .q          (st_q[k])
    );
  end

  assign st_ready[STAGES] = out_ready;

  // ---- output: the last stage register is the output holding register ----
  assign last      = st_q[STAGES-1];
  assign last_sum  = last.sum[WIDTH:0];
  assign out_valid = last.valid;
  assign out_sum   = out_valid ? last_sum : '0;
  assign in_ready  = out_ready || !last.valid;

`ifdef ADDRS_RESIDUE_CHECK_EN
  logic [MAX_W:0] sum_ext;
  logic [2:0]     res_tot;
  logic [1:0]     res_exp;
  logic [1:0]     res_sum;

  always_comb begin
    sum_ext          = '0;
    sum_ext[WIDTH:0] = last_sum;
    res_tot          = {1'b0, last.res_a} + {1'b0, last.res_b};
    res_exp          = (res_tot >= 3'd3) ? 2'(res_tot - 3'd3) : res_tot[1:0];
    res_sum          = mod3(sum_ext, WIDTH + 1);
  end

  assign out_err = last.valid && (res_exp != res_sum);

  always_ff @(posedge clk) begin
    if (rst)                                   err_cnt <= 8'd0;
    else if (out_valid && out_ready && out_err) err_cnt <= sat_inc(err_cnt);
  end
`else
  assign out_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

  // Operand copies, the final carry-out and the upper padding are not needed past the last stage.
  logic unused_bits;
  assign unused_bits = ^{last.a, last.b, last.carry, last.sum, last.res_a, last.res_b, st_ready[0]};

endmodule

// File: tb/tb_addrs_pipe.sv
// Self-checking bench for addrs_pipe (WIDTH=8, CHUNK=4, two stages).
// A negedge monitor pushes the expected result of every accepted operand pair
// into a queue and pops/compares it on every output transfer.
module tb_addrs_pipe;

  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_a;
  logic signed [W-1:0] in_b;
  logic                in_sub;
  logic                out_valid;
  logic                out_ready;
  logic signed [W:0]   out_sum;
  logic                out_err;
  logic [7:0]          err_cnt;

  int         checks   = 0;
  int         errors   = 0;
  int         xfer_cnt = 0;
  bit         mon_en   = 1'b0;
  bit         fault_on = 1'b0;
  logic [W:0] sb[$];
  logic [W:0] mon_exp;
  logic       mon_err_exp;

  always #5 clk = ~clk;

  addrs_pipe #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  function automatic logic [W:0] model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                       input logic s);
    int r;
    r = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    return r[W:0];
  endfunction

  // Scoreboard: compare on output transfer, then record the input transfer.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: out_sum=%h with no pending result", out_sum);
        end else begin
          mon_exp     = sb.pop_front();
          mon_err_exp = fault_on ? ~mon_exp[0] : 1'b0;
          if (fault_on) mon_exp[0] = 1'b1;
          if (out_sum !== mon_exp) begin
            errors++;
            $display("FAIL sb_sum: got %h expected %h", out_sum, mon_exp);
          end
          checks++;
          if (out_err !== mon_err_exp) begin
            errors++;
            $display("FAIL sb_err: got %b expected %b", out_err, mon_err_exp);
          end
        end
        xfer_cnt++;
      end else if (!out_valid) begin
        checks++;
        if (out_sum !== '0) begin
          errors++;
          $display("FAIL out_sum_idle: got %h expected 000", out_sum);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_sub));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== '0)     begin errors++; $display("FAIL rst_out_sum: got %h expected 000", out_sum); end
    checks++; if (out_err !== 1'b0)   begin errors++; $display("FAIL rst_out_err: got %b expected 0", out_err); end
    checks++; if (err_cnt !== 8'd0)   begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_corner();
    logic [W-1:0] ta [5] = '{8'h7F, 8'h80, 8'h80, 8'h7F, 8'hFF};
    logic [W-1:0] tb [5] = '{8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF};
    logic         ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W:0]   te [5] = '{9'h080, 9'h101, 9'h000, 9'h0FF, 9'h1FE};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = ta[i]; in_b = tb[i]; in_sub = ts[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL corner%0d_early: out_valid=%b expected 0", i, out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL corner%0d_valid: out_valid=%b expected 1", i, out_valid); end
      checks++; if (out_sum !== te[i])  begin errors++; $display("FAIL corner%0d_sum: got %h expected %h", i, out_sum, te[i]); end
      checks++; if (out_err !== 1'b0)   begin errors++; $display("FAIL corner%0d_err: got %b expected 0", i, out_err); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL corner%0d_after: out_valid=%b expected 0", i, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int   start;
    logic exp_v;
    start     = xfer_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) begin
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 10) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b expected 1", i, in_ready); end
      end
      exp_v = (i >= 2 && i <= 11);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_out_valid%0d: got %b expected %b", i, out_valid, exp_v); end
      @(posedge clk); #1;
    end
    checks++; if (xfer_cnt - start != 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", xfer_cnt - start); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_stall();
    int                start;
    int                issued;
    bit                accepted;
    logic signed [W:0] held;
    start  = xfer_cnt;
    issued = 0;
    held   = '0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      in_valid  = (issued < 6);
      @(negedge clk);
      if (c < 5) begin
        checks++; if (in_ready !== (c < 2)) begin errors++; $display("FAIL stall_in_ready%0d: got %b expected %b", c, in_ready, (c < 2)); end
      end
      if (c >= 2 && c < 5) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b expected 1", c, out_valid); end
        if (c == 2) held = out_sum;
        else begin
          checks++; if (out_sum !== held) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", c, out_sum, held); end
        end
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) begin
        issued++;
        in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    checks++; if (xfer_cnt - start != 6) begin errors++; $display("FAIL stall_count: got %0d expected 6", xfer_cnt - start); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_rst_flight();
    int start;
    start     = xfer_cnt;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
    @(posedge clk); #1;
    in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    checks++; if (err_cnt !== 8'd0)   begin errors++; $display("FAIL flush_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_emerge%0d: out_valid=%b expected 0", i, out_valid); end
    end
    @(posedge clk); #1;
    checks++; if (xfer_cnt != start) begin errors++; $display("FAIL flush_count: got %0d expected %0d", xfer_cnt, start); end
  endtask

`ifdef ADDRS_RESIDUE_CHECK_EN
  task automatic test_residue();
    out_ready = 1'b1;
    force dut.last_sum[0] = 1'b1;
    fault_on = 1'b1;
    for (int i = 0; i < 303; i++) begin
      if (i < 300) begin
        // A+A is always even, so forcing bit 0 high is always a fault.
        in_valid = 1'b1; in_a = 8'($urandom); in_b = in_a; in_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i == 3) begin
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL res_first: err_cnt=%0d expected 1", err_cnt); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL res_saturate: err_cnt=%0d expected 255", err_cnt); end
    @(posedge clk); #1;
    fault_on = 1'b0;
    release dut.last_sum[0];
  endtask
`else
  task automatic test_err_default();
    @(negedge clk);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_cnt_default: got %0d expected 0", err_cnt); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL out_err_default: got %b expected 0", out_err); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_corner();
    test_back_to_back();
    test_stall();
    test_rst_flight();
`ifdef ADDRS_RESIDUE_CHECK_EN
    test_residue();
`else
    test_err_default();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
